uart_rx: RTL and testbench

Receives the 8N1 serial stream produced by the UART transmit path (`tx_uart_o`) and delivers bytes on a valid/ready stream. Synchronizes the asynchronous line and validates the start bit at mid-bit. Samples data LSB-first at bit centres and checks the stop bit. Buffers received bytes in a small FIFO so the consumer (core MMIO/peripheral bus) can stall without losing back-to-back characters.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; full/empty from an extra pointer MSB.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[AW-1:0]];

    // Storage and pointers; the array is cleared so dout reads 0 out of reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, FWFT receive buffer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BAUD = 868,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   rx_uart_i,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   busy_o,
    output logic                   frame_err_o,
    output logic                   overrun_o
);

    localparam int CW = $clog2(CLKS_PER_BAUD);
    localparam int H  = CLKS_PER_BAUD / 2;
    localparam logic [CW-1:0] HALF_LOAD = CW'(H - 1);
    localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BAUD - 1);

    if (CLKS_PER_BAUD < 4) begin : g_chk_baud
        $error("uart_rx: CLKS_PER_BAUD must be >= 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    rx_state_t              state, state_d;
    logic [CW-1:0]          cnt, cnt_val;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shift_q;
    logic                   rx_meta, rx_sync, rx_prev;
    logic [1:0]             sync_fill;
    logic                   armed, start_edge;
    logic                   cnt_load, bit_clr, bit_shift, disarm;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                   frame_err, overrun;

    // Two-flop synchronizer plus previous value for falling-edge detect.
    // sync_fill marks when rx_sync holds a real line sample rather than the
    // reset value, so a line held low across reset cannot arm the receiver.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= rx_uart_i;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign start_edge = rx_prev && !rx_sync;

    // Arm once the line is genuinely seen idle-high; a bad stop bit disarms.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                                           armed <= 1'b0;
        else if (disarm)                                       armed <= 1'b0;
        else if (state == IDLE && rx_sync && sync_fill[1])     armed <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_d;
    end

    // Next state and per-cycle strobes for the counter, shifter and FIFO.
    always_comb begin
        state_d   = state;
        cnt_load  = 1'b0;
        cnt_val   = BAUD_LOAD;
        bit_clr   = 1'b0;
        bit_shift = 1'b0;
        fifo_push = 1'b0;
        frame_err = 1'b0;
        overrun   = 1'b0;
        disarm    = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && start_edge) begin
                    cnt_load = 1'b1;
                    cnt_val  = HALF_LOAD;
                    state_d  = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (rx_sync) begin
                        state_d = IDLE;             // glitch, not a start bit
                    end else begin
                        cnt_load = 1'b1;
                        bit_clr  = 1'b1;
                        state_d  = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    bit_shift = 1'b1;
                    cnt_load  = 1'b1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                    if (rx_sync) begin
                        if (fifo_full && !fifo_pop) overrun   = 1'b1;
                        else                        fifo_push = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                        disarm    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit-period down-counter; holds at zero instead of wrapping.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)         cnt <= '0;
        else if (cnt_load)   cnt <= cnt_val;
        else if (cnt != '0)  cnt <= cnt - CW'(1);
    end

    // LSB-first data capture at bit centres.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bit_idx <= '0;
            shift_q <= '0;
        end else if (bit_clr) begin
            bit_idx <= '0;
        end else if (bit_shift) begin
            shift_q[bit_idx] <= rx_sync;
            bit_idx          <= bit_idx + 3'd1;
        end
    end

    assign fifo_pop    = valid_o && ready_i;
    assign valid_o     = !fifo_empty;
    assign busy_o      = (state != IDLE);
    assign frame_err_o = frame_err;
    assign overrun_o   = overrun;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (shift_q),
        .dout   (data_o),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BAUD=16, FIFO_DEPTH=4.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid, busy, fe, ov;

    uart_rx #(.CLKS_PER_BAUD(CPB), .FIFO_DEPTH(4)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .rx_uart_i   (rx),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .busy_o      (busy),
        .frame_err_o (fe),
        .overrun_o   (ov)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    bit rand_rdy = 1'b0;

    // Observation: edge times, pulse counts and the stream of accepted bytes.
    int         valid_rise = -1, busy_rise = -1, busy_fall = -1;
    int         fe_cnt = 0, fe_cyc = -1, ov_cnt = 0, ov_cyc = -1;
    logic       valid_q = 1'b0, busy_q = 1'b0;
    logic [7:0] rx_q [$];

    always @(negedge clk) begin
        if (valid && !valid_q) valid_rise = cyc;
        if (busy && !busy_q)   busy_rise  = cyc;
        if (!busy && busy_q)   busy_fall  = cyc;
        if (fe) begin fe_cnt++; fe_cyc = cyc; end
        if (ov) begin ov_cnt++; ov_cyc = cyc; end
        if (valid && ready) rx_q.push_back(data);
        valid_q = valid;
        busy_q  = busy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) ready = 1'($urandom_range(0, 1));
    endtask

    // One 8N1 frame, one bit per CPB cycles. pulse_at >= 0 drives ready high
    // for exactly that frame-relative cycle and low otherwise.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input int pulse_at, output int t0);
        logic [9:0] bits;
        bits = {stop_b, d, 1'b0};
        t0 = cyc;
        for (int k = 0; k < 10 * CPB; k++) begin
            rx = bits[k / CPB];
            if (pulse_at >= 0) ready = (k == pulse_at);
            tick();
        end
        rx = 1'b1;
    endtask

    int    t, fe0, ov0;
    string msg;

    initial begin
        rstn = 1'b0; rx = 1'b1; ready = 1'b1;
        repeat (3) tick();
        check("rst_data",  32'(data),  32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_ferr",  32'(fe),    32'h0);
        check("rst_ovr",   32'(ov),    32'h0);
        rstn = 1'b1;
        repeat (5) tick();

        // 'h' with timing: E = t+2, S = t+2+8+144
        rx_q.delete();
        send_frame(8'h68, 1'b1, -1, t);
        tick();
        check("h_busy_rise",  32'(busy_rise),  32'(t + 3));
        check("h_valid_rise", 32'(valid_rise), 32'(t + 155));
        check("h_busy_fall",  32'(busy_fall),  32'(t + 155));
        check("h_count",      32'(rx_q.size()), 32'd1);
        check("h_data",       32'(q_at(0)),     32'h68);

        // 3-cycle glitch: busy for H cycles, nothing delivered
        rx_q.delete();
        fe0 = fe_cnt;
        t = cyc;
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (40) tick();
        check("gl_busy_rise", 32'(busy_rise), 32'(t + 3));
        check("gl_busy_len",  32'(busy_fall - busy_rise), 32'd8);
        check("gl_ferr",      32'(fe_cnt), 32'(fe0));
        check("gl_count",     32'(rx_q.size()), 32'd0);

        // bad stop bit, then recovery with 0x3C
        send_frame(8'hA5, 1'b0, -1, t);
        check("fe_count", 32'(fe_cnt), 32'(fe0 + 1));
        check("fe_cycle", 32'(fe_cyc), 32'(t + 154));
        check("fe_valid", 32'(valid),  32'h0);
        repeat (5) tick();
        send_frame(8'h3C, 1'b1, -1, t);
        repeat (5) tick();
        check("rec_count", 32'(rx_q.size()), 32'd1);
        check("rec_data",  32'(q_at(0)),     32'h3C);
        check("rec_ferr",  32'(fe_cnt),      32'(fe0 + 1));

        // overrun: 5 bytes into a 4-deep FIFO with no consumer
        rx_q.delete();
        ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, t);
        check("ov_count", 32'(ov_cnt), 32'(ov0 + 1));
        check("ov_cycle", 32'(ov_cyc), 32'(t + 154));
        check("ov_valid", 32'(valid),  32'h1);
        ready = 1'b1;
        repeat (10) tick();
        check("ov_drain_n", 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("ov_drain[%0d]", i), 32'(q_at(i)), 32'(i + 1));

        // full FIFO with a pop exactly at the stop sample: nothing lost
        rx_q.delete();
        ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1, t);
        send_frame(8'h05, 1'b1, 154, t);
        check("pp_ovr", 32'(ov_cnt), 32'(ov0));
        ready = 1'b1;
        repeat (10) tick();
        check("pp_drain_n", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("pp_drain[%0d]", i), 32'(q_at(i)), 32'(i + 1));

        // back-to-back text with a random consumer
        rx_q.delete();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        msg = "hello, world! It is a beautiful day!";
        rand_rdy = 1'b1;
        for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 1'b1, -1, t);
        rand_rdy = 1'b0;
        ready = 1'b1;
        repeat (20) tick();
        check("txt_count", 32'(rx_q.size()), 32'd36);
        for (int i = 0; i < 36; i++)
            check($sformatf("txt[%0d]", i), 32'(q_at(i)), 32'(msg[i]));
        check("txt_ferr", 32'(fe_cnt), 32'(fe0));
        check("txt_ovr",  32'(ov_cnt), 32'(ov0));

        // reset mid-frame with a queued byte, line held low through release
        ready = 1'b0;
        send_frame(8'h77, 1'b1, -1, t);
        check("mr_queued", 32'(valid), 32'h1);
        rx = 1'b0;
        repeat (40) tick();
        check("mr_busy_pre", 32'(busy), 32'h1);
        rstn = 1'b0;
        repeat (3) tick();
        check("mr_busy_rst",  32'(busy),  32'h0);
        check("mr_valid_rst", 32'(valid), 32'h0);
        check("mr_data_rst",  32'(data),  32'h0);
        busy_rise = -1;
        fe0 = fe_cnt;
        rstn = 1'b1;
        repeat (100) tick();
        check("mr_no_start", 32'(busy_rise), 32'hFFFF_FFFF);
        check("mr_no_ferr",  32'(fe_cnt),    32'(fe0));
        rx = 1'b1;
        repeat (20) tick();
        rx_q.delete();
        ready = 1'b1;
        send_frame(8'h55, 1'b1, -1, t);
        repeat (5) tick();
        check("mr_count", 32'(rx_q.size()), 32'd1);
        check("mr_data",  32'(q_at(0)),     32'h55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
